// File: rtl/neuron_mac_stage.sv
// neuron_mac_stage
//   Per-neuron multiply-accumulate stage that feeds the sigmoid lookup ROM.
//   Streams numWeight signed fixed-point samples, multiplies each one by a
//   weight from a local weight RAM, accumulates with saturation, adds a bias
//   and presents the saturated sum together with its top bits as the ROM
//   address.
// Ports
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   in_data/in_valid     input sample stream; in_ready = sample accepted
//   w_wen/w_addr/w_data  weight RAM write port (usable in any state)
//   b_wen/b_data         bias register load
//   out_sum              saturated neuron sum (held until next result)
//   sig_x                top sigInWidth bits of out_sum (sigmoid ROM address)
//   out_valid            one-cycle pulse marking a new out_sum/sig_x
module neuron_mac_stage #(
  parameter int numWeight  = 784,
  parameter int dataWidth  = 16,
  parameter int fracBits   = 12,
  parameter int sigInWidth = 10,
  parameter int addrWidth  = $clog2(numWeight)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [dataWidth-1:0]  in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  w_wen,
  input  logic [addrWidth-1:0]  w_addr,
  input  logic [dataWidth-1:0]  w_data,
  input  logic                  b_wen,
  input  logic [dataWidth-1:0]  b_data,
  output logic [dataWidth-1:0]  out_sum,
  output logic [sigInWidth-1:0] sig_x,
  output logic                  out_valid
);

  localparam int CW = addrWidth + 1;
  localparam logic signed [dataWidth-1:0] SMAX = {1'b0, {(dataWidth-1){1'b1}}};
  localparam logic signed [dataWidth-1:0] SMIN = {1'b1, {(dataWidth-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, BIAS, DONE} state_t;

  state_t                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic signed [dataWidth-1:0]   x_q, x_d;
  logic                          v1_q, v1_d;
  logic signed [dataWidth-1:0]   prod_q, prod_d;
  logic                          v2_q, v2_d;
  logic signed [dataWidth-1:0]   acc_q, acc_d;
  logic signed [dataWidth-1:0]   sum_q, sum_d;
  logic                          out_valid_q, out_valid_d;
  logic [dataWidth-1:0]          bias_q, bias_d;
  logic signed [dataWidth-1:0]   w_rd_q;
  logic [dataWidth-1:0]          mem [numWeight];
  logic                          accept;

  function automatic logic signed [dataWidth-1:0] sat_add(
    input logic signed [dataWidth-1:0] a,
    input logic signed [dataWidth-1:0] b
  );
    logic signed [dataWidth:0] s;
    s = {a[dataWidth-1], a} + {b[dataWidth-1], b};
    if (s[dataWidth] != s[dataWidth-1]) return s[dataWidth] ? SMIN : SMAX;
    return s[dataWidth-1:0];
  endfunction

  // Full-width product, rescaled by fracBits, then clamped: overflow exists
  // whenever the bits above the result's sign bit are not a pure sign extension.
  function automatic logic signed [dataWidth-1:0] sat_mul(
    input logic signed [dataWidth-1:0] a,
    input logic signed [dataWidth-1:0] b
  );
    logic signed [2*dataWidth-1:0] p;
    logic [dataWidth:0]            hi;
    p  = a * b;
    p  = p >>> fracBits;
    hi = p[2*dataWidth-1:dataWidth-1];
    if (hi != '0 && hi != '1) return p[2*dataWidth-1] ? SMIN : SMAX;
    return p[dataWidth-1:0];
  endfunction

  assign accept = in_valid & in_ready;

  // Weight RAM: synchronous read of the slot for the sample being accepted;
  // a same-cycle write to that slot is seen only by later reads.
  always_ff @(posedge clk) begin
    if (accept) w_rd_q <= mem[cnt_q[addrWidth-1:0]];
    if (w_wen)  mem[w_addr] <= w_data;
  end

  // Bias survives reset.
  always_ff @(posedge clk) begin
    bias_q <= bias_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      v1_q        <= 1'b0;
      prod_q      <= '0;
      v2_q        <= 1'b0;
      acc_q       <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      v1_q        <= v1_d;
      prod_q      <= prod_d;
      v2_q        <= v2_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = ACCUM;
      ACCUM: if (accept && cnt_q == CW'(numWeight - 1)) state_d = DRAIN;
      // Leave once the last product is being folded in and nothing is behind it.
      DRAIN: if (v2_q && !v1_q) state_d = BIAS;
      BIAS:  state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = rst_n && (state_q == IDLE || state_q == ACCUM) && (cnt_q < CW'(numWeight));
  end

  always_comb begin
    bias_d      = b_wen ? b_data : bias_q;
    cnt_d       = cnt_q;
    if (accept) cnt_d = cnt_q + 1'b1;
    if (state_q == DONE) cnt_d = '0;
    x_d         = accept ? in_data : x_q;
    v1_d        = accept;
    prod_d      = v1_q ? sat_mul(x_q, w_rd_q) : prod_q;
    v2_d        = v1_q;
    acc_d       = acc_q;
    if (v2_q) acc_d = sat_add(acc_q, prod_q);
    if (state_q == DONE) acc_d = '0;
    sum_d       = (state_q == BIAS) ? sat_add(acc_q, bias_q) : sum_q;
    out_valid_d = (state_q == BIAS);
  end

  assign out_sum   = sum_q;
  assign sig_x     = sum_q[dataWidth-1 -: sigInWidth];
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_neuron_mac_stage.sv
// Scoreboard bench for neuron_mac_stage (numWeight=4, 16-bit Q4.12 data).
module tb_neuron_mac_stage;
  localparam int NW = 4;
  localparam int DW = 16;
  localparam int SW = 10;
  localparam int AW = 2;

  typedef logic [DW-1:0] vec_t [NW];
  typedef struct {
    logic [DW-1:0] sum;
    logic [SW-1:0] sx;
    string         name;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          w_wen = 1'b0;
  logic [AW-1:0] w_addr = '0;
  logic [DW-1:0] w_data = '0;
  logic          b_wen = 1'b0;
  logic [DW-1:0] b_data = '0;
  logic [DW-1:0] out_sum;
  logic [SW-1:0] sig_x;
  logic          out_valid;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  neuron_mac_stage #(
    .numWeight(NW), .dataWidth(DW), .fracBits(12), .sigInWidth(SW), .addrWidth(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .w_wen(w_wen), .w_addr(w_addr), .w_data(w_data),
    .b_wen(b_wen), .b_data(b_data),
    .out_sum(out_sum), .sig_x(sig_x), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got out_sum %h expected no out_valid", out_sum);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_sum"}, 32'(out_sum), 32'(e.sum));
        check({e.name, "_sigx"}, 32'(sig_x), 32'(e.sx));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input vec_t w, input logic [DW-1:0] b);
    for (int i = 0; i < NW; i++) begin
      w_wen  = 1'b1;
      w_addr = AW'(i);
      w_data = w[i];
      b_wen  = (i == 0);
      b_data = b;
      step();
    end
    w_wen = 1'b0;
    b_wen = 1'b0;
  endtask

  // Offers samples until n are accepted; gaps toggles in_valid, junk keeps
  // in_valid high with a large value while the stage must refuse it.
  task automatic send(input vec_t d, input int n, input bit gaps, input bit junk);
    int  i = 0;
    int  budget = 0;
    bit  took;
    while (i < n && budget < 100) begin
      in_valid = !(gaps && (budget % 2 == 1));
      in_data  = d[i];
      @(negedge clk);
      took = in_valid && in_ready;
      step();
      if (took) i++;
      budget++;
    end
    in_valid = 1'b0;
    if (i < n) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got %0d accepts expected %0d", i, n);
    end
    if (junk) begin
      for (int k = 0; k < 3; k++) begin
        in_valid = 1'b1;
        in_data  = 16'h7FFF;
        @(negedge clk);
        check("ready_low_after_last", 32'(in_ready), 32'd0);
        step();
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_result();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL result_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    repeat (3) step();
  endtask

  task automatic run(input string name, input vec_t w, input logic [DW-1:0] b,
                     input vec_t d, input logic [DW-1:0] sum, input logic [SW-1:0] sx,
                     input bit gaps, input bit junk);
    exp_t e;
    load(w, b);
    e.sum = sum; e.sx = sx; e.name = name;
    sb.push_back(e);
    send(d, NW, gaps, junk);
    wait_result();
  endtask

  vec_t w_one, w_max, w_mix, w_sev, d_one, d_max, d_min, d_mix, d_ord;

  initial begin
    w_one = '{16'h1000, 16'h1000, 16'h1000, 16'h1000};
    w_max = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    w_mix = '{16'h2000, 16'h1000, 16'h1000, 16'h1000};
    w_sev = '{16'h7000, 16'h7000, 16'h7000, 16'h7000};
    d_one = '{16'h1000, 16'h1000, 16'h1000, 16'h1000};
    d_max = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    d_min = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    d_mix = '{16'h1000, 16'h2000, 16'hE000, 16'h0800};
    d_ord = '{16'h1000, 16'h1000, 16'hF000, 16'hF000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_sig_x", 32'(sig_x), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(in_ready), 32'd1);
    step();

    run("nominal",  w_one, 16'h0800, d_one, 16'h4800, 10'h120, 1'b0, 1'b0);
    run("sat_pos",  w_max, 16'h0800, d_max, 16'h7FFF, 10'h1FF, 1'b0, 1'b0);
    run("sat_neg",  w_max, 16'h8000, d_min, 16'h8000, 10'h200, 1'b0, 1'b0);
    run("bubbles",  w_one, 16'h0800, d_one, 16'h4800, 10'h120, 1'b1, 1'b1);
    run("mixed",    w_mix, 16'h0800, d_mix, 16'h3000, 10'h0C0, 1'b0, 1'b0);
    run("clamp_ord", w_sev, 16'h0000, d_ord, 16'h9FFF, 10'h27F, 1'b0, 1'b0);

    // Abort after two accepts; the monitor flags any pulse from this run.
    load(w_one, 16'h0800);
    send(d_one, 2, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_abort", 32'(in_ready), 32'd1);
    check("sum_after_abort", 32'(out_sum), 32'd0);
    step();
    repeat (6) step();
    run("after_abort", w_one, 16'h0800, d_one, 16'h4800, 10'h120, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
